interval_timer_ctrl: RTL

//  Owns the interval timing resource for the traffic light FSM: stores the three

---
 rtl/interval_timer_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/interval_timer_ctrl.sv
// Interval timer for the traffic light controller: holds base/extended/yellow intervals,
// counts them down on 1 Hz ticks and pulses expired. Optional TIMER_REMAINING_EN adds Remaining.
//
// state | meaning
// IDLE  | no interval running, waiting for start_timer
// COUNT | interval loaded, decrementing on each One_Hz_Enable
// DONE  | interval finished, expired high for this single cycle
module interval_timer_ctrl #(
   parameter int WIDTH  = 4,
   parameter int T_BASE = 6,
   parameter int T_EXT  = 3,
   parameter int T_YEL  = 2
) (
   input  logic             clk,
   input  logic             Reset_N,
   input  logic             One_Hz_Enable,
   input  logic             start_timer,
   input  logic [1:0]       time_selector,
   input  logic             Prog_Sync,
   input  logic [1:0]       Time_Parameter_Selector,
   input  logic [WIDTH-1:0] Time_Value,
`ifdef TIMER_REMAINING_EN
   output logic [WIDTH-1:0] Remaining,
`endif
   output logic             expired,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DEF_BASE = WIDTH'(T_BASE);
   localparam logic [WIDTH-1:0] DEF_EXT  = WIDTH'(T_EXT);
   localparam logic [WIDTH-1:0] DEF_YEL  = WIDTH'(T_YEL);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] count, count_nxt;
   logic [WIDTH-1:0] param_base, param_ext, param_yel;
   logic [WIDTH-1:0] sel_value;
   logic             prog_prev;
   logic             prog_edge;

   assign prog_edge = Prog_Sync & ~prog_prev;

   // A programmed value of zero restores the default so a loaded count is never zero.
   always_ff @(posedge clk or negedge Reset_N) begin
      if (!Reset_N) begin
         prog_prev  <= 1'b0;
         param_base <= DEF_BASE;
         param_ext  <= DEF_EXT;
         param_yel  <= DEF_YEL;
      end else begin
         prog_prev <= Prog_Sync;
         if (prog_edge) begin
            case (Time_Parameter_Selector)
               2'b00:   param_base <= (Time_Value == '0) ? DEF_BASE : Time_Value;
               2'b01:   param_ext  <= (Time_Value == '0) ? DEF_EXT  : Time_Value;
               2'b10:   param_yel  <= (Time_Value == '0) ? DEF_YEL  : Time_Value;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      case (time_selector)
         2'b01:   sel_value = param_ext;
         2'b10:   sel_value = param_yel;
         default: sel_value = param_base;
      endcase
   end

   always_ff @(posedge clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Program edge outranks start; start outranks a same-cycle tick.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      if (prog_edge) begin
         state_nxt = IDLE;
         count_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_timer) begin
                  count_nxt = sel_value;
                  state_nxt = COUNT;
               end
            end
            COUNT: begin
               if (start_timer) begin
                  count_nxt = sel_value;
               end else if (One_Hz_Enable) begin
                  if (count <= ONE) state_nxt = DONE;
                  else              count_nxt = count - ONE;
               end
            end
            DONE: begin
               if (start_timer) begin
                  count_nxt = sel_value;
                  state_nxt = COUNT;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               count_nxt = '0;
            end
         endcase
      end
   end

   assign busy    = (state == COUNT);
   assign expired = (state == DONE);

`ifdef TIMER_REMAINING_EN
   assign Remaining = (state == COUNT) ? count : '0;
`endif

endmodule
